pipeline_register_skid: RTL and testbench

Parametrised successor to the plain enable register: a one-stage elastic pipeline register with a valid/ready handshake on both sides and a two-entry skid buffer. It sustains one beat per cycle with no combinational path from `out_ready_i` to `in_ready_o`. It is used between stages of the RISC-V core, for example fetch→decode or execute→writeback, where backpressure and flush are needed.

---
 rtl/pipeline_register_skid.sv | 93 +++++++++
 tb/tb_pipeline_register_skid.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_register_skid.sv
// Elastic one-stage pipeline register with a valid/ready handshake on both sides and a skid entry.
// Optional synchronous flush is enabled by defining PIPELINE_REGISTER_SKID_FLUSH_EN.
module pipeline_register_skid #(
  parameter int                 nb_bits   = 32,
  parameter logic [nb_bits-1:0] rst_value = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [nb_bits-1:0] D_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [nb_bits-1:0] Q_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [nb_bits-1:0] main_reg, main_next;
  logic [nb_bits-1:0] skid_reg, skid_next;
  logic               accept, take;

  // Handshake flags come only from registered state, so ready never sees out_ready_i.
  assign out_valid_o = (state_reg != EMPTY);
  assign in_ready_o  = (state_reg != FULL);
  assign Q_o         = main_reg;

  assign accept = in_valid_i & in_ready_o;
  assign take   = out_valid_o & out_ready_i;

`ifndef PIPELINE_REGISTER_SKID_FLUSH_EN
  logic flush_unused;
  assign flush_unused = flush_i;
`endif

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = BUSY;
          main_next  = D_i;
        end
      end
      BUSY: begin
        if (accept && take) begin
          main_next = D_i;
        end else if (accept) begin
          state_next = FULL;
          skid_next  = D_i;
        end else if (take) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          state_next = BUSY;
          main_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
`ifdef PIPELINE_REGISTER_SKID_FLUSH_EN
    // Flush drops every held or in-flight beat but leaves the data registers untouched.
    if (flush_i) begin
      state_next = EMPTY;
      main_next  = main_reg;
      skid_next  = skid_reg;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= EMPTY;
      main_reg  <= rst_value;
      skid_reg  <= rst_value;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

endmodule

// File: tb/tb_pipeline_register_skid.sv
// Scoreboard bench for pipeline_register_skid: directed reset/stream/backpressure/flush cases plus random stress.
module tb_pipeline_register_skid;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];

`ifdef PIPELINE_REGISTER_SKID_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  pipeline_register_skid #(
    .nb_bits  (8),
    .rst_value(8'hA5)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .D_i        (d),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .Q_o        (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Delivered sequence must be exactly base, base+1, ... (n beats); clears the record afterwards.
  task automatic check_seq(input string name, input int base, input int n);
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      if (got[i] !== 8'(base + i)) check({name, "_order"}, got[i], 8'(base + i));
    end
    vectors++;
    got.delete();
  endtask

  // Issue side: every accepted beat is expected later, in order; a flush or reset discards them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (FLUSH_EN && flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(d);
    end
  end

  always @(negedge rst_n) exp_q.delete();

  // Monitor: a beat leaves whenever out_valid and out_ready meet at the coming edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !(FLUSH_EN && flush)) begin
      got.push_back(q);
      if (exp_q.size() == 0) check("unexpected_beat", q, 32'hFFFF_FFFF);
      else check("scoreboard", q, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cycles;
    logic acc;
    logic ir;
    logic r;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = 8'h00;
    #12;
    check("reset_q", q, 8'hA5);
    check("reset_valid", out_valid, 1'b0);
    check("reset_ready", in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("post_reset_q", q, 8'hA5);
    check("post_reset_valid", out_valid, 1'b0);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_valid = 1'b1; d = 8'(v);
      step();
      check("stream_q", q, v);
      check("stream_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("stream_empty", out_valid, 1'b0);
    check_seq("stream_seq", 1, 4);

    // Backpressure fills main then skid.
    out_ready = 1'b0;
    in_valid = 1'b1; d = 8'd10; step();
    check("bp_busy_ready", in_ready, 1'b1);
    d = 8'd11; step();
    d = 8'd12; step();
    check("bp_full_ready", in_ready, 1'b0);
    check("bp_full_valid", out_valid, 1'b1);
    check("bp_full_q", q, 8'd10);
    out_ready = 1'b1; #1;
    check("bp_ready_comb", in_ready, 1'b0);
    step();
    check("bp_drain_q1", q, 8'd11);
    step();
    check("bp_drain_q2", q, 8'd12);
    in_valid = 1'b0;
    step(); step();
    check_seq("bp_seq", 10, 3);

    // Flush from FULL with a further beat offered.
    out_ready = 1'b0;
    in_valid = 1'b1; d = 8'd20; step();
    d = 8'd21; step();
    d = 8'd22; flush = 1'b1; step();
    flush = 1'b0;
    if (FLUSH_EN) begin
      in_valid = 1'b0;
      check("flush_valid", out_valid, 1'b0);
      check("flush_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      step(); step();
      check_seq("flush_seq", 20, 0);
    end else begin
      check("noflush_valid", out_valid, 1'b1);
      check("noflush_q", q, 8'd20);
      out_ready = 1'b1;
      step(); step();
      in_valid = 1'b0;
      step(); step();
      check_seq("noflush_seq", 20, 3);
    end

    // Asynchronous reset mid-cycle while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; d = 8'd30; step();
    d = 8'd31; step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", out_valid, 1'b0);
    check("areset_ready", in_ready, 1'b1);
    check("areset_q", q, 8'hA5);
    @(negedge clk) rst_n = 1'b1;
    step();
    in_valid = 1'b1; d = 8'd40; out_ready = 1'b1;
    step();
    check("after_reset_q", q, 8'd40);
    in_valid = 1'b0;
    step();
    check_seq("after_reset_seq", 40, 1);

    // Random stress; data is the beat index so order is checked against a counter.
    sent = 0;
    cycles = 0;
    while (sent < 1000 && cycles < 20000) begin
      in_valid = $urandom_range(0, 1) == 1;
      d = 8'(sent);
      r = $urandom_range(0, 1) == 1;
      out_ready = r; #1;
      ir = in_ready;
      out_ready = !r; #1;
      if (in_ready !== ir) check("stress_ready_comb", in_ready, ir);
      out_ready = r;
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
      cycles++;
    end
    check("stress_sent", sent, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) step();
    check("stress_drained", out_valid, 1'b0);
    check_seq("stress_seq", 0, 1000);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
